enc_gen: RTL and testbench



---
 rtl/enc_pkg.sv | 35 +++
 rtl/enc_gen_prescaler.sv | 36 +++
 rtl/enc_gen.sv | 133 +++++++++++++
 tb/tb_enc_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder generator: FSM states,
// {A,B} levels per quadrature phase, direction codes and the phase stepper.
package enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_RUN   = 3'b010,
        ST_DRAIN = 3'b100
    } state_t;

    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b10;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b01;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic logic [1:0] ph_to_ab(input logic [1:0] ph);
        logic [1:0] ab;
        case (ph)
            2'd0:    ab = AB_PH0;
            2'd1:    ab = AB_PH1;
            2'd2:    ab = AB_PH2;
            default: ab = AB_PH3;
        endcase
        return ab;
    endfunction

    // The phase index is two bits wide, so wrap-around in both directions is free.
    function automatic logic [1:0] ph_step(input logic [1:0] ph, input logic dir);
        return (dir == DIR_REV) ? ph - 2'd1 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/enc_gen_prescaler.sv
// Quarter-period prescaler: counts 0..per-1, re-latches the period on load
// and on every terminal count, and strobes tc for one cycle at per-1.
module enc_gen_prescaler #(
    parameter int P_CNT_W = 32
) (
    input  logic               CLK,
    input  logic               I_RST,
    input  logic               load,
    input  logic               run,
    input  logic [P_CNT_W-1:0] period,
    output logic               tc,
    output logic               cnt_zero
);

    logic [P_CNT_W-1:0] cnt;
    logic [P_CNT_W-1:0] per;
    logic [P_CNT_W-1:0] period_eff;

    // A zero period would never reach terminal count; treat it as one clock.
    assign period_eff = (period == '0) ? P_CNT_W'(1) : period;
    assign tc         = run && (cnt == per - P_CNT_W'(1));
    assign cnt_zero   = (cnt == '0);

    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) begin
            cnt <= '0;
            per <= P_CNT_W'(1);
        end else if (load || tc) begin
            cnt <= '0;
            per <= period_eff;
        end else if (run) begin
            cnt <= cnt + P_CNT_W'(1);
        end
    end

endmodule

// File: rtl/enc_gen.sv
// Quadrature encoder generator: A/B/Z waveforms at a programmable quarter period.
// Define ENC_GEN_Z_EN to generate the Z index pulse; otherwise O_Z is tied low.
module enc_gen
    import enc_pkg::*;
#(
    parameter int P_CNT_W = 32,
    parameter int P_PPR   = 1024,
    parameter int P_POS_W = $clog2(4*P_PPR)
) (
    input  logic               CLK,
    input  logic               I_RST,
    input  logic               I_EN,
    input  logic               I_DIR,
    input  logic [P_CNT_W-1:0] I_PERIOD,
    output logic               O_A,
    output logic               O_B,
    output logic               O_Z,
    output logic [P_POS_W-1:0] O_POS,
    output logic               O_BUSY,
    output logic               O_DONE
);

    localparam logic [P_POS_W-1:0] POS_MAX = P_POS_W'(4*P_PPR - 1);

    state_t             state, state_n;
    logic [1:0]         ph, ph_n, ph_stp;
    logic [P_POS_W-1:0] pos, pos_n, pos_stp;
    logic               dir_q, dir_n, step_dir;
    logic               done_q, done_n;
    logic               tc, cnt_zero;

    enc_gen_prescaler #(
        .P_CNT_W (P_CNT_W)
    ) u_prescaler (
        .CLK      (CLK),
        .I_RST    (I_RST),
        .load     (state == ST_IDLE),
        .run      (state != ST_IDLE),
        .period   (I_PERIOD),
        .tc       (tc),
        .cnt_zero (cnt_zero)
    );

    // Direction is live in RUN but frozen while draining back to phase 0.
    always_comb begin
        step_dir = (state == ST_DRAIN) ? dir_q : I_DIR;
        ph_stp   = ph_step(ph, step_dir);
        if (step_dir == DIR_REV) pos_stp = (pos == '0) ? POS_MAX : pos - P_POS_W'(1);
        else                     pos_stp = (pos == POS_MAX) ? '0 : pos + P_POS_W'(1);
    end

    // NOTE: every next-state signal gets its default first so no path infers a latch.
    always_comb begin
        state_n = state;
        ph_n    = ph;
        pos_n   = pos;
        dir_n   = dir_q;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                ph_n  = '0;
                pos_n = '0;
                if (I_EN) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (tc) begin
                    ph_n  = ph_stp;
                    pos_n = pos_stp;
                end
                if (!I_EN) begin
                    state_n = ST_DRAIN;
                    dir_n   = I_DIR;
                end
            end
            ST_DRAIN: begin
                if ((ph == 2'd0 && cnt_zero) || (tc && ph_stp == 2'd0)) begin
                    state_n = ST_IDLE;
                    ph_n    = '0;
                    pos_n   = '0;
                    done_n  = 1'b1;
                end else if (tc) begin
                    ph_n  = ph_stp;
                    pos_n = pos_stp;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) begin
            state  <= ST_IDLE;
            ph     <= '0;
            pos    <= '0;
            dir_q  <= DIR_FWD;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            ph     <= ph_n;
            pos    <= pos_n;
            dir_q  <= dir_n;
            done_q <= done_n;
        end
    end

    // Output stage re-registers the core so every output lags it by one clock
    // together, which keeps O_DONE aligned with the falling edge of O_BUSY.
    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) begin
            O_A    <= 1'b0;
            O_B    <= 1'b0;
            O_POS  <= '0;
            O_BUSY <= 1'b0;
            O_DONE <= 1'b0;
        end else begin
            {O_A, O_B} <= ph_to_ab(ph);
            O_POS      <= pos;
            O_BUSY     <= (state != ST_IDLE);
            O_DONE     <= done_q;
        end
    end

`ifdef ENC_GEN_Z_EN
    always_ff @(posedge CLK or posedge I_RST) begin
        if (I_RST) O_Z <= 1'b0;
        else       O_Z <= (state != ST_IDLE) && (pos == '0);
    end
`else
    assign O_Z = 1'b0;
`endif

endmodule

// File: tb/tb_enc_gen.sv
// Directed, table-driven bench for enc_gen (P_PPR=4); Z expectations follow ENC_GEN_Z_EN.
module tb_enc_gen;

    localparam int CW  = 8;
    localparam int PPR = 4;
    localparam int PW  = 4;
`ifdef ENC_GEN_Z_EN
    localparam logic ZE = 1'b1;
`else
    localparam logic ZE = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          I_RST = 1'b0;
    logic          I_EN = 1'b0;
    logic          I_DIR = 1'b0;
    logic [CW-1:0] I_PERIOD = '0;
    logic          O_A, O_B, O_Z, O_BUSY, O_DONE;
    logic [PW-1:0] O_POS;

    enc_gen #(
        .P_CNT_W (CW),
        .P_PPR   (PPR),
        .P_POS_W (PW)
    ) dut (
        .CLK      (CLK),
        .I_RST    (I_RST),
        .I_EN     (I_EN),
        .I_DIR    (I_DIR),
        .I_PERIOD (I_PERIOD),
        .O_A      (O_A),
        .O_B      (O_B),
        .O_Z      (O_Z),
        .O_POS    (O_POS),
        .O_BUSY   (O_BUSY),
        .O_DONE   (O_DONE)
    );

    always #5 CLK = ~CLK;

    // cyc = clocks after the edge that first samples I_EN high
    typedef struct {
        int   scen;
        int   cyc;
        logic a;
        logic b;
        logic z;
        int   pos;
        logic busy;
        logic done;
    } vec_t;

    // en_low / glit / chg_cyc: stimulus applied right after sampling that cycle (-1 = never)
    typedef struct {
        logic dir;
        int   period;
        int   en_low;
        int   glit;
        int   chg_cyc;
        int   chg_val;
        int   last;
    } scen_t;

    vec_t  vecs[$];
    scen_t scens[5];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int s, input int c, input logic [1:0] ab, input logic z,
                       input int pos, input logic busy, input logic done);
        vec_t v;
        v.scen = s; v.cyc = c; v.a = ab[1]; v.b = ab[0]; v.z = z;
        v.pos = pos; v.busy = busy; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic check_rows(input int s, input int k);
        foreach (vecs[i]) begin
            if (vecs[i].scen == s && vecs[i].cyc == k) begin
                check($sformatf("s%0d c%0d A", s, k),    32'(O_A),    32'(vecs[i].a));
                check($sformatf("s%0d c%0d B", s, k),    32'(O_B),    32'(vecs[i].b));
                check($sformatf("s%0d c%0d Z", s, k),    32'(O_Z),    32'(vecs[i].z));
                check($sformatf("s%0d c%0d POS", s, k),  32'(O_POS),  32'(vecs[i].pos));
                check($sformatf("s%0d c%0d BUSY", s, k), 32'(O_BUSY), 32'(vecs[i].busy));
                check($sformatf("s%0d c%0d DONE", s, k), 32'(O_DONE), 32'(vecs[i].done));
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        I_RST = 1'b1;
        repeat (2) @(negedge CLK);
        I_RST = 1'b0;
    endtask

    task automatic run_scenario(input int s);
        scen_t c;
        c = scens[s];
        I_EN     = 1'b0;
        I_DIR    = c.dir;
        I_PERIOD = CW'(c.period);
        apply_reset();
        @(negedge CLK);
        I_EN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_rows(s, 0);
        for (int k = 1; k <= c.last; k++) begin
            @(negedge CLK);
            check_rows(s, k);
            if (k == c.en_low)   I_EN = 1'b0;
            if (k == c.glit)     I_EN = 1'b1;
            if (k == c.glit + 1) I_EN = 1'b0;
            if (k == c.chg_cyc)  I_PERIOD = CW'(c.chg_val);
        end
        I_EN = 1'b0;
    endtask

    initial begin
        // dir, period, en_low, glit, chg_cyc, chg_val, last
        scens[0] = '{1'b0, 3, -1, -1, -1, 0, 52};   // forward, full revolution
        scens[1] = '{1'b1, 2, -1, -1, -1, 0, 10};   // reverse
        scens[2] = '{1'b0, 0, -1, -1, -1, 0, 5};    // zero period -> 1 clock
        scens[3] = '{1'b0, 5, 12, 17, -1, 0, 22};   // stop at ph=2, EN glitch in drain
        scens[4] = '{1'b0, 4, -1, -1, 6, 7, 16};    // period 4 -> 7 mid-state

        add(0, 0,  2'b00, 1'b0, 0,  1'b0, 1'b0);
        add(0, 1,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(0, 3,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(0, 4,  2'b10, 1'b0, 1,  1'b1, 1'b0);
        add(0, 6,  2'b10, 1'b0, 1,  1'b1, 1'b0);
        add(0, 7,  2'b11, 1'b0, 2,  1'b1, 1'b0);
        add(0, 10, 2'b01, 1'b0, 3,  1'b1, 1'b0);
        add(0, 13, 2'b00, 1'b0, 4,  1'b1, 1'b0);
        add(0, 48, 2'b01, 1'b0, 15, 1'b1, 1'b0);
        add(0, 49, 2'b00, ZE,   0,  1'b1, 1'b0);
        add(0, 51, 2'b00, ZE,   0,  1'b1, 1'b0);
        add(0, 52, 2'b10, 1'b0, 1,  1'b1, 1'b0);

        add(1, 1,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(1, 2,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(1, 3,  2'b01, 1'b0, 15, 1'b1, 1'b0);
        add(1, 4,  2'b01, 1'b0, 15, 1'b1, 1'b0);
        add(1, 5,  2'b11, 1'b0, 14, 1'b1, 1'b0);
        add(1, 7,  2'b10, 1'b0, 13, 1'b1, 1'b0);
        add(1, 9,  2'b00, 1'b0, 12, 1'b1, 1'b0);

        add(2, 1,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(2, 2,  2'b10, 1'b0, 1,  1'b1, 1'b0);
        add(2, 3,  2'b11, 1'b0, 2,  1'b1, 1'b0);
        add(2, 4,  2'b01, 1'b0, 3,  1'b1, 1'b0);
        add(2, 5,  2'b00, 1'b0, 4,  1'b1, 1'b0);

        add(3, 1,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(3, 11, 2'b11, 1'b0, 2,  1'b1, 1'b0);
        add(3, 15, 2'b11, 1'b0, 2,  1'b1, 1'b0);
        add(3, 16, 2'b01, 1'b0, 3,  1'b1, 1'b0);
        add(3, 19, 2'b01, 1'b0, 3,  1'b1, 1'b0);
        add(3, 20, 2'b01, 1'b0, 3,  1'b1, 1'b0);
        add(3, 21, 2'b00, 1'b0, 0,  1'b0, 1'b1);
        add(3, 22, 2'b00, 1'b0, 0,  1'b0, 1'b0);

        add(4, 4,  2'b00, ZE,   0,  1'b1, 1'b0);
        add(4, 5,  2'b10, 1'b0, 1,  1'b1, 1'b0);
        add(4, 8,  2'b10, 1'b0, 1,  1'b1, 1'b0);
        add(4, 9,  2'b11, 1'b0, 2,  1'b1, 1'b0);
        add(4, 15, 2'b11, 1'b0, 2,  1'b1, 1'b0);
        add(4, 16, 2'b01, 1'b0, 3,  1'b1, 1'b0);

        // reset then idle with I_EN low
        #2 I_RST = 1'b1;
        #1 check("reset outs", 32'({O_A, O_B, O_Z, O_BUSY, O_DONE, O_POS}), 32'd0);
        @(negedge CLK);
        I_RST = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check($sformatf("idle c%0d", k), 32'({O_A, O_B, O_Z, O_BUSY, O_DONE, O_POS}), 32'd0);
        end

        for (int s = 0; s < 5; s++) run_scenario(s);

        // asynchronous reset while running at ph=2
        I_DIR    = 1'b0;
        I_PERIOD = CW'(3);
        apply_reset();
        @(negedge CLK);
        I_EN = 1'b1;
        @(posedge CLK);
        repeat (9) @(negedge CLK);
        check("pre-rst AB",   32'({O_A, O_B}), 32'(2'b11));
        check("pre-rst BUSY", 32'(O_BUSY),     32'd1);
        #2 I_RST = 1'b1;
        #1 check("async rst outs", 32'({O_A, O_B, O_Z, O_BUSY, O_DONE, O_POS}), 32'd0);
        I_EN = 1'b0;
        @(negedge CLK);
        I_RST = 1'b0;
        @(negedge CLK);
        check("post-rst outs", 32'({O_A, O_B, O_Z, O_BUSY, O_DONE, O_POS}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
